// File: rtl/pipeline_mem_host_bridge.sv
// pipeline_mem_host_bridge
// ------------------------
// Host-side responder for the software-register memory interface of the
// pipeline datapath. It picks up a new host command when the sequence
// number in mem_cmd_reg changes, stalls the pipeline, performs one word
// read or write on the imem/dmem second port, and reports the result.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   mem_addr_reg             host word address (only [AW-1:0] used)
//   mem_cmd_reg              [31:24] sequence, [2:0] opcode
//                            (1 imem wr, 2 imem rd, 3 dmem wr, 4 dmem rd)
//   mem_data_write_reg       host write data
//   mem_data_read_reg        data from the last completed read
//   mem_status_reg           [31:24] last seq, [3] illegal, [2] verify
//                            mismatch, [1] ack timeout, [0] busy
//   cpu_stall_req/ack        pipeline hold handshake
//   imem_*/dmem_*            second ports of instruction/data memory
//                            (synchronous read, 1-cycle latency)
//
// Build option: define MEM_HOST_BRIDGE_VERIFY_EN to read back every write
// and flag a mismatch in status bit [2].

module pipeline_mem_host_bridge #(
    parameter int AW          = 9,
    parameter int DW          = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   mem_addr_reg,
    input  logic [31:0]   mem_cmd_reg,
    input  logic [31:0]   mem_data_write_reg,
    output logic [31:0]   mem_data_read_reg,
    output logic [31:0]   mem_status_reg,
    output logic          cpu_stall_req,
    input  logic          cpu_stall_ack,
    output logic [AW-1:0] imem_addr,
    output logic [DW-1:0] imem_wdata,
    output logic          imem_we,
    input  logic [DW-1:0] imem_rdata,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    output logic          dmem_we,
    input  logic [DW-1:0] dmem_rdata
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

`ifdef MEM_HOST_BRIDGE_VERIFY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_STALL, S_ACCESS, S_RDWAIT, S_VRD, S_VCHK, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_STALL, S_ACCESS, S_RDWAIT, S_DONE
    } state_t;
`endif

    state_t          state, state_nxt;
    logic [7:0]      serviced_seq;
    logic [7:0]      cmd_seq;
    logic [2:0]      cmd_op;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [CW-1:0]   stall_cnt;
    logic            busy;
    logic            err_illegal;
    logic            err_timeout;
    logic            err_verify;
    logic [31:0]     rdata_q;

    logic            new_cmd;
    logic            new_legal;
    logic            op_write;
    logic            op_imem;
    logic            stall_expired;
    logic [DW-1:0]   sel_rdata;

    // Upper address/command bits are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{mem_addr_reg, mem_cmd_reg[23:3], mem_data_write_reg};

    assign new_cmd       = (state == S_IDLE) && (mem_cmd_reg[31:24] != serviced_seq);
    assign new_legal     = (mem_cmd_reg[2:0] >= 3'd1) && (mem_cmd_reg[2:0] <= 3'd4);
    assign op_write      = (cmd_op == 3'd1) || (cmd_op == 3'd3);
    assign op_imem       = (cmd_op == 3'd1) || (cmd_op == 3'd2);
    assign stall_expired = !cpu_stall_ack && (stall_cnt == CW'(ACK_TIMEOUT - 1));
    assign sel_rdata     = op_imem ? imem_rdata : dmem_rdata;

    // NOTE: every output of this block gets a default first so that no
    // state/path combination can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        cpu_stall_req = 1'b0;
        imem_addr     = '0;
        imem_wdata    = '0;
        imem_we       = 1'b0;
        dmem_addr     = '0;
        dmem_wdata    = '0;
        dmem_we       = 1'b0;

        case (state)
            S_IDLE: begin
                if (new_cmd) state_nxt = new_legal ? S_STALL : S_DONE;
            end
            S_STALL: begin
                cpu_stall_req = 1'b1;
                if (cpu_stall_ack)      state_nxt = S_ACCESS;
                else if (stall_expired) state_nxt = S_DONE;
            end
            S_ACCESS: begin
                cpu_stall_req = 1'b1;
`ifdef MEM_HOST_BRIDGE_VERIFY_EN
                state_nxt = op_write ? S_VRD : S_RDWAIT;
`else
                state_nxt = op_write ? S_DONE : S_RDWAIT;
`endif
            end
            S_RDWAIT: begin
                cpu_stall_req = 1'b1;
                state_nxt     = S_DONE;
            end
`ifdef MEM_HOST_BRIDGE_VERIFY_EN
            S_VRD: begin
                cpu_stall_req = 1'b1;
                state_nxt     = S_VCHK;
            end
            S_VCHK: begin
                cpu_stall_req = 1'b1;
                state_nxt     = S_DONE;
            end
`endif
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Address stays on the selected port from ACCESS until the read data
        // has been captured; write data and strobe only in ACCESS.
        if (cpu_stall_req && state != S_STALL) begin
            if (op_imem) imem_addr = cmd_addr;
            else         dmem_addr = cmd_addr;
        end
        if (state == S_ACCESS && op_write) begin
            if (op_imem) begin
                imem_wdata = cmd_wdata;
                imem_we    = 1'b1;
            end else begin
                dmem_wdata = cmd_wdata;
                dmem_we    = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            serviced_seq <= '0;
            cmd_seq      <= '0;
            cmd_op       <= '0;
            cmd_addr     <= '0;
            cmd_wdata    <= '0;
            stall_cnt    <= '0;
            busy         <= 1'b0;
            err_illegal  <= 1'b0;
            err_timeout  <= 1'b0;
            err_verify   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (new_cmd) begin
                        // Snapshot the host registers; later writes by the
                        // host cannot disturb the command in flight.
                        cmd_seq     <= mem_cmd_reg[31:24];
                        cmd_op      <= mem_cmd_reg[2:0];
                        cmd_addr    <= mem_addr_reg[AW-1:0];
                        cmd_wdata   <= mem_data_write_reg[DW-1:0];
                        stall_cnt   <= '0;
                        busy        <= 1'b1;
                        err_illegal <= !new_legal;
                        err_timeout <= 1'b0;
                        err_verify  <= 1'b0;
                    end
                end
                S_STALL: begin
                    stall_cnt <= stall_cnt + 1'b1;
                    if (stall_expired) err_timeout <= 1'b1;
                end
                S_RDWAIT: rdata_q <= 32'(sel_rdata);
`ifdef MEM_HOST_BRIDGE_VERIFY_EN
                S_VCHK: begin
                    rdata_q    <= 32'(sel_rdata);
                    err_verify <= (sel_rdata != cmd_wdata);
                end
`endif
                S_DONE: begin
                    serviced_seq <= cmd_seq;
                    busy         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_data_read_reg = rdata_q;
    assign mem_status_reg    = {serviced_seq, 20'b0, err_illegal, err_verify,
                                err_timeout, busy};

endmodule

// File: tb/tb_pipeline_mem_host_bridge.sv
// Directed bench for pipeline_mem_host_bridge: models both memories as
// synchronous 1-cycle-latency RAMs and steps through host commands with
// hand-computed expected status/data values.

module tb_pipeline_mem_host_bridge;

    localparam int AW = 9;
    localparam int DW = 32;
`ifdef MEM_HOST_BRIDGE_VERIFY_EN
    localparam int WR_LAT = 5;
`else
    localparam int WR_LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   mem_addr_reg;
    logic [31:0]   mem_cmd_reg;
    logic [31:0]   mem_data_write_reg;
    logic [31:0]   mem_data_read_reg;
    logic [31:0]   mem_status_reg;
    logic          cpu_stall_req;
    logic          cpu_stall_ack;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          imem_we;
    logic [DW-1:0] imem_rdata;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_we;
    logic [DW-1:0] dmem_rdata;
    logic          corrupt;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_mem_host_bridge #(.AW(AW), .DW(DW), .ACK_TIMEOUT(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .mem_addr_reg       (mem_addr_reg),
        .mem_cmd_reg        (mem_cmd_reg),
        .mem_data_write_reg (mem_data_write_reg),
        .mem_data_read_reg  (mem_data_read_reg),
        .mem_status_reg     (mem_status_reg),
        .cpu_stall_req      (cpu_stall_req),
        .cpu_stall_ack      (cpu_stall_ack),
        .imem_addr          (imem_addr),
        .imem_wdata         (imem_wdata),
        .imem_we            (imem_we),
        .imem_rdata         (imem_rdata),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_we            (dmem_we),
        .dmem_rdata         (dmem_rdata)
    );

    always #5 clk = ~clk;

    // Memory models: write on strobe, registered read of the pre-edge
    // contents. The dmem read path can be corrupted to provoke a verify error.
    logic [DW-1:0] imem_m [512];
    logic [DW-1:0] dmem_m [512];
    always @(posedge clk) begin
        if (imem_we) imem_m[imem_addr] <= imem_wdata;
        if (dmem_we) dmem_m[dmem_addr] <= dmem_wdata;
        imem_rdata <= imem_m[imem_addr];
        dmem_rdata <= dmem_m[dmem_addr] ^ (corrupt ? 32'h0000_0100 : 32'h0);
    end

    // Free-running event counters; the stimulus takes differences.
    int            imem_we_cnt = 0;
    int            dmem_we_cnt = 0;
    int            stall_cnt = 0;
    int            busy_rise_cnt = 0;
    logic          busy_prev = 1'b0;
    logic [AW-1:0] last_iaddr = '0;
    logic [DW-1:0] last_iwdata = '0;
    always @(negedge clk) begin
        if (imem_we) begin
            imem_we_cnt = imem_we_cnt + 1;
            last_iaddr  = imem_addr;
            last_iwdata = imem_wdata;
        end
        if (dmem_we)       dmem_we_cnt = dmem_we_cnt + 1;
        if (cpu_stall_req) stall_cnt = stall_cnt + 1;
        if (mem_status_reg[0] && !busy_prev) busy_rise_cnt = busy_rise_cnt + 1;
        busy_prev = mem_status_reg[0];
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int iw0, dw0, st0, br0;

    initial begin
        rst = 1'b1;
        mem_cmd_reg = '0;
        mem_addr_reg = '0;
        mem_data_write_reg = '0;
        cpu_stall_ack = 1'b1;
        corrupt = 1'b0;
        tick(3);
        check("rst_status", mem_status_reg, 32'h0);
        check("rst_stall", 32'(cpu_stall_req), 32'h0);
        check("rst_rdata", mem_data_read_reg, 32'h0);
        check("rst_we", 32'({imem_we, dmem_we}), 32'h0);

        // Sequence 0 right after reset is not a new command.
        rst = 1'b0;
        mem_cmd_reg = 32'h0000_0003;
        mem_addr_reg = 32'h1;
        mem_data_write_reg = 32'h1;
        dw0 = dmem_we_cnt;
        tick(4);
        check("seq0_status", mem_status_reg, 32'h0);
        check("seq0_no_we", 32'(dmem_we_cnt - dw0), 32'h0);

        // DMEM write, seq 1.
        mem_addr_reg = 32'h005;
        mem_data_write_reg = 32'hDEAD_BEEF;
        mem_cmd_reg = 32'h0100_0003;
        dw0 = dmem_we_cnt;
        iw0 = imem_we_cnt;
        tick(1);
        check("wr_busy", mem_status_reg, 32'h0000_0001);
        tick(1);
        check("wr_dmem_we", 32'(dmem_we), 32'h1);
        check("wr_dmem_addr", 32'(dmem_addr), 32'h5);
        check("wr_dmem_wdata", dmem_wdata, 32'hDEAD_BEEF);
        check("wr_stall", 32'(cpu_stall_req), 32'h1);
        tick(WR_LAT - 2);
        check("wr_done_stall", 32'(cpu_stall_req), 32'h0);
        check("wr_done_busy", mem_status_reg, 32'h0000_0001);
        tick(1);
        check("wr_status", mem_status_reg, 32'h0100_0000);
        check("wr_pulses", 32'(dmem_we_cnt - dw0), 32'h1);
        check("wr_no_imem", 32'(imem_we_cnt - iw0), 32'h0);

        // DMEM read, seq 2, reads back the value just written.
        mem_cmd_reg = 32'h0200_0004;
        iw0 = imem_we_cnt;
        dw0 = dmem_we_cnt;
        tick(2);
        check("rd_addr", 32'(dmem_addr), 32'h5);
        check("rd_we", 32'(dmem_we), 32'h0);
        tick(2);
        check("rd_data", mem_data_read_reg, 32'hDEAD_BEEF);
        check("rd_busy", mem_status_reg, 32'h0100_0001);
        tick(1);
        check("rd_status", mem_status_reg, 32'h0200_0000);
        check("rd_no_we", 32'((imem_we_cnt - iw0) + (dmem_we_cnt - dw0)), 32'h0);

        // IMEM write at top address with no ack: timeout after 16 cycles.
        cpu_stall_ack = 1'b0;
        mem_addr_reg = 32'h0000_03FF;
        mem_data_write_reg = 32'h0BAD_F00D;
        mem_cmd_reg = 32'h0300_0001;
        iw0 = imem_we_cnt;
        st0 = stall_cnt;
        tick(1);
        check("to_busy", mem_status_reg, 32'h0200_0001);
        tick(15);
        check("to_last_stall", 32'(cpu_stall_req), 32'h1);
        tick(1);
        check("to_done_stall", 32'(cpu_stall_req), 32'h0);
        check("to_done_status", mem_status_reg, 32'h0200_0003);
        tick(1);
        check("to_status", mem_status_reg, 32'h0300_0002);
        check("to_stall_cycles", 32'(stall_cnt - st0), 32'd16);
        check("to_no_imem", 32'(imem_we_cnt - iw0), 32'h0);

        // Illegal opcode: no stall, straight to DONE.
        cpu_stall_ack = 1'b1;
        mem_cmd_reg = 32'h0400_0007;
        st0 = stall_cnt;
        tick(1);
        check("ill_done", mem_status_reg, 32'h0300_0009);
        tick(1);
        check("ill_status", mem_status_reg, 32'h0400_0008);
        check("ill_no_stall", 32'(stall_cnt - st0), 32'h0);

        // Sequence changes while busy: only the value seen after DONE runs.
        mem_addr_reg = 32'h005;
        mem_cmd_reg = 32'h0500_0004;
        br0 = busy_rise_cnt;
        iw0 = imem_we_cnt;
        dw0 = dmem_we_cnt;
        tick(1);
        mem_addr_reg = 32'h020;
        mem_cmd_reg = 32'h0600_0004;
        tick(1);
        mem_addr_reg = 32'h010;
        mem_data_write_reg = 32'h1234_5678;
        mem_cmd_reg = 32'h0700_0001;
        tick(3);
        check("q_first_status", mem_status_reg, 32'h0500_0000);
        check("q_first_data", mem_data_read_reg, 32'hDEAD_BEEF);
        tick(1);
        check("q_second_busy", mem_status_reg, 32'h0500_0001);
        mem_addr_reg = 32'h1FE;
        mem_data_write_reg = 32'hFFFF_FFFF;
        tick(WR_LAT);
        check("q_status", mem_status_reg, 32'h0700_0000);
        check("q_accepts", 32'(busy_rise_cnt - br0), 32'd2);
        check("q_imem_pulses", 32'(imem_we_cnt - iw0), 32'h1);
        check("q_imem_addr", 32'(last_iaddr), 32'h010);
        check("q_imem_wdata", last_iwdata, 32'h1234_5678);
        check("q_no_dmem", 32'(dmem_we_cnt - dw0), 32'h0);

        // IMEM read-back of the latched write.
        mem_addr_reg = 32'h010;
        mem_cmd_reg = 32'h0800_0002;
        tick(5);
        check("ird_data", mem_data_read_reg, 32'h1234_5678);
        check("ird_status", mem_status_reg, 32'h0800_0000);

        // Reset while a write is stalled.
        cpu_stall_ack = 1'b0;
        mem_addr_reg = 32'h007;
        mem_data_write_reg = 32'h55;
        mem_cmd_reg = 32'h0900_0003;
        dw0 = dmem_we_cnt;
        tick(3);
        check("rs_stalled", 32'(cpu_stall_req), 32'h1);
        rst = 1'b1;
        mem_cmd_reg = 32'h0;
        tick(1);
        check("rs_stall", 32'(cpu_stall_req), 32'h0);
        check("rs_status", mem_status_reg, 32'h0);
        check("rs_we", 32'(dmem_we), 32'h0);
        rst = 1'b0;
        cpu_stall_ack = 1'b1;
        tick(3);
        check("rs_idle_status", mem_status_reg, 32'h0);
        check("rs_no_we", 32'(dmem_we_cnt - dw0), 32'h0);

        // Sequence wrap 0xFF -> 0x00.
        mem_data_write_reg = 32'hA5A5_0F0F;
        mem_cmd_reg = 32'hFF00_0003;
        tick(1);
        check("wrap_busy", mem_status_reg, 32'h0000_0001);
        tick(WR_LAT);
        check("wrap_ff", mem_status_reg, 32'hFF00_0000);
        mem_cmd_reg = 32'h0000_0004;
        tick(1);
        check("wrap_00_busy", mem_status_reg, 32'hFF00_0001);
        tick(4);
        check("wrap_00", mem_status_reg, 32'h0000_0000);
        check("wrap_data", mem_data_read_reg, 32'hA5A5_0F0F);

`ifdef MEM_HOST_BRIDGE_VERIFY_EN
        // Corrupted read-back flags a verify mismatch.
        corrupt = 1'b1;
        mem_addr_reg = 32'h008;
        mem_data_write_reg = 32'h1;
        mem_cmd_reg = 32'h0100_0003;
        tick(1 + WR_LAT);
        check("vfy_status", mem_status_reg, 32'h0100_0004);
        check("vfy_data", mem_data_read_reg, 32'h0000_0101);
        corrupt = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
